inst_fetch_unit: RTL and testbench



---
 rtl/inst_fetch_unit_pkg.sv | 23 ++
 rtl/fetch_pc_next.sv | 56 +++++
 rtl/inst_fetch_unit.sv | 152 +++++++++++++++
 tb/tb_inst_fetch_unit.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_unit_pkg
// Description : Shared definitions for the instruction-fetch unit and for
//               the blocks around it (decode, memory model): fetch state
//               encoding, instruction width and the default reset PC / HALT
//               encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package inst_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_e;

    localparam int          INST_BYTES        = 4;
    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_HALT_INST = 32'hFFFF_FFFF;

endpackage
`default_nettype wire

// File: rtl/fetch_pc_next.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_next
// Description : Combinational next-PC selector for the fetch unit.
//               Priority: redirect > sequential increment > hold.
//               Redirect targets are word-aligned and folded into the
//               memory range; a misaligned or out-of-range target raises
//               addr_err while the corrected address is still used.
// Ports       : pc             - current byte PC
//               fetch          - a fetch is accepted this cycle
//               redirect_valid - execute requests a PC change
//               redirect_pc    - requested target byte address
//               pc_next        - PC value for the next cycle
//               addr_err       - redirect target was misaligned/out of range
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_next
    import inst_fetch_unit_pkg::*;
#(
    parameter int MEM_BYTES = 32
) (
    input  logic [31:0] pc,
    input  logic        fetch,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc_next,
    output logic        addr_err
);

    // MEM_BYTES is a power of two, so clearing the low two bits and taking
    // the address modulo the memory size is a single mask.
    localparam logic [31:0] c_addr_mask = 32'(MEM_BYTES - 1) & ~32'(INST_BYTES - 1);

    logic [31:0] w_pc_inc;
    logic [31:0] w_target;
    logic        w_misaligned;
    logic        w_out_of_range;

    assign w_pc_inc       = (pc + 32'(INST_BYTES)) & c_addr_mask;
    assign w_target       = redirect_pc & c_addr_mask;
    assign w_misaligned   = |redirect_pc[1:0];
    assign w_out_of_range = (redirect_pc >= 32'(MEM_BYTES));

    always_comb begin
        pc_next = pc;
        if (redirect_valid) begin
            pc_next = w_target;
        end else if (fetch) begin
            pc_next = w_pc_inc;
        end
    end

    assign addr_err = redirect_valid && (w_misaligned || w_out_of_range);

endmodule
`default_nettype wire

// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_unit
// Description : Instruction-fetch initiator. Holds the PC, reads one
//               32-bit word per cycle from instruction memory and registers
//               it with its PC into a one-entry valid/ready slot toward
//               decode. Accepts redirects from execute and stops fetching
//               after delivering a HALT instruction.
// Ports       : clk, rst_n        - clock / async active-low reset
//               start             - pulse: leave IDLE/HALT and fetch
//               im_address, im_en - memory request (combinational)
//               im_inst           - memory read data, same cycle
//               redirect_valid/pc - PC change request from execute
//               if_valid/ready    - output slot handshake
//               if_inst, if_pc    - registered instruction and its PC
//               addr_err          - pulse on bad redirect target
//               fetch_count       - instructions handed to decode (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int          MEM_BYTES = 32,
    parameter logic [31:0] HALT_INST = DEFAULT_HALT_INST
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [31:0] im_address,
    output logic        im_en,
    input  logic [31:0] im_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic        addr_err,
    output logic [31:0] fetch_count
);

    fetch_state_e r_state;
    fetch_state_e w_state_next;
    logic         w_im_en;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_next;
    logic         w_addr_err;
    logic         r_if_valid;
    logic [31:0]  r_if_inst;
    logic [31:0]  r_if_pc;
    logic         r_addr_err;
    logic [31:0]  r_fetch_count;
    logic         w_handshake;

    assign w_handshake = r_if_valid && if_ready;

    fetch_pc_next #(
        .MEM_BYTES      (MEM_BYTES)
    ) u_pc_next (
        .pc             (r_pc),
        .fetch          (w_im_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pc_next        (w_pc_next),
        .addr_err       (w_addr_err)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and memory enable. A fetch is only issued when the
    // slot is empty or being drained this cycle, and never alongside a
    // redirect (the redirect flushes the slot instead).
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_im_en      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_im_en = !redirect_valid && (!r_if_valid || if_ready);
                if (w_im_en && (im_inst == HALT_INST)) begin
                    w_state_next = ST_HALT;
                end
            end
            ST_HALT: begin
                if (start || redirect_valid) begin
                    w_state_next = ST_FETCH;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // PC, output slot, error pulse and delivered-instruction counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_if_valid    <= 1'b0;
            r_if_inst     <= 32'h0;
            r_if_pc       <= 32'h0;
            r_addr_err    <= 1'b0;
            r_fetch_count <= 32'h0;
        end else begin
            r_pc       <= w_pc_next;
            r_addr_err <= w_addr_err;

            // A handshake completing in a redirect cycle still counts.
            if (w_handshake) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end

            if (redirect_valid) begin
                r_if_valid <= 1'b0;
            end else if (w_im_en) begin
                r_if_valid <= 1'b1;
                r_if_inst  <= im_inst;
                r_if_pc    <= r_pc;
            end else if (w_handshake) begin
                r_if_valid <= 1'b0;
            end
        end
    end

    assign im_address  = r_pc;
    assign im_en       = w_im_en;
    assign if_valid    = r_if_valid;
    assign if_inst     = r_if_inst;
    assign if_pc       = r_if_pc;
    assign addr_err    = r_addr_err;
    assign fetch_count = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_fetch_unit
// Description : Self-checking bench for inst_fetch_unit. A behavioural
//               model tracks mode, PC, output slot and counters; a compare
//               process checks every DUT output against it on each falling
//               edge, and directed scenarios add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_unit;
    import inst_fetch_unit_pkg::*;

    localparam int          MEM = 32;
    localparam logic [31:0] HLT = 32'hFFFF_FFFF;
    localparam int          M_IDLE  = 0;
    localparam int          M_FETCH = 1;
    localparam int          M_HALT  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [31:0] im_address;
    logic        im_en;
    logic [31:0] im_inst;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        addr_err;
    logic [31:0] fetch_count;

    logic [31:0] mem [8];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    inst_fetch_unit #(
        .RESET_PC  (32'h0),
        .MEM_BYTES (MEM),
        .HALT_INST (HLT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .im_address     (im_address),
        .im_en          (im_en),
        .im_inst        (im_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_inst        (if_inst),
        .if_pc          (if_pc),
        .addr_err       (addr_err),
        .fetch_count    (fetch_count)
    );

    // Memory answers in the same cycle; the address is kept in range.
    assign im_inst = mem[(im_address / 4) % 8];

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    int          m_mode;
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_inst;
    logic [31:0] m_ipc;
    logic        m_err;
    logic [31:0] m_count;
    logic        m_fetch_now;

    always_comb begin
        m_fetch_now = 1'b0;
        if (m_mode == M_FETCH && !redirect_valid && (!m_valid || if_ready)) begin
            m_fetch_now = 1'b1;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode  <= M_IDLE;
            m_pc    <= 32'h0;
            m_valid <= 1'b0;
            m_inst  <= 32'h0;
            m_ipc   <= 32'h0;
            m_err   <= 1'b0;
            m_count <= 32'h0;
        end else begin
            if (m_valid && if_ready) m_count <= m_count + 1;
            m_err <= redirect_valid && ((redirect_pc % 4 != 0) || (redirect_pc >= MEM));
            if (redirect_valid) begin
                m_pc    <= (redirect_pc - (redirect_pc % 4)) % MEM;
                m_valid <= 1'b0;
                if (m_mode == M_HALT || (m_mode == M_IDLE && start)) m_mode <= M_FETCH;
            end else if (m_fetch_now) begin
                m_valid <= 1'b1;
                m_inst  <= mem[m_pc / 4];
                m_ipc   <= m_pc;
                m_pc    <= (m_pc + 4) % MEM;
                if (mem[m_pc / 4] == HLT) m_mode <= M_HALT;
            end else begin
                if (m_valid && if_ready) m_valid <= 1'b0;
                if (start && m_mode != M_FETCH) m_mode <= M_FETCH;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        check("im_address", im_address, m_pc);
        check("im_en", {31'h0, im_en}, {31'h0, m_fetch_now});
        check("if_valid", {31'h0, if_valid}, {31'h0, m_valid});
        check("addr_err", {31'h0, addr_err}, {31'h0, m_err});
        check("fetch_count", fetch_count, m_count);
        if (m_valid) begin
            check("if_inst", if_inst, m_inst);
            check("if_pc", if_pc, m_ipc);
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        start = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        mem[0] = 32'h0123_0000; mem[1] = 32'h1415_0000;
        mem[2] = 32'hF0B7_AB1E; mem[3] = 32'hD07B_0005;
        mem[4] = 32'h36B4_0000; mem[5] = 32'hA5A5_0014;
        mem[6] = 32'h0000_0018; mem[7] = 32'hC0DE_001C;
        #1 rst_n = 1'b0;
        step();
        step();
        check("reset if_valid", {31'h0, if_valid}, 32'h0);
        check("reset fetch_count", fetch_count, 32'h0);
        check("reset im_address", im_address, 32'h0);
        rst_n = 1'b1;

        // 1: streaming fetch
        if_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        #1 check("t1 first im_en", {31'h0, im_en}, 32'h1);
        check("t1 addr0", im_address, 32'h0);
        step();
        check("t1 if_inst0", if_inst, 32'h0123_0000);
        check("t1 if_pc0", if_pc, 32'h0);
        check("t1 addr4", im_address, 32'h4);
        step(); check("t1 addr8", im_address, 32'h8);
        step(); check("t1 addr12", im_address, 32'hC);
        step(); check("t1 addr16", im_address, 32'h10);
        step();
        step(); check("t1 count5", fetch_count, 32'd5);

        // 2: backpressure
        do_reset();
        if_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        #1 check("t2 im_en held", {31'h0, im_en}, 32'h0);
        check("t2 pc held", im_address, 32'h4);
        check("t2 inst held", if_inst, 32'h0123_0000);
        step();
        check("t2 inst still", if_inst, 32'h0123_0000);
        if_ready = 1'b1;
        step();
        check("t2 next inst", if_inst, 32'h1415_0000);
        check("t2 next pc", if_pc, 32'h4);
        check("t2 count1", fetch_count, 32'd1);

        // 3: redirect flushes a valid slot
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h8;
        step();
        redirect_valid = 1'b0;
        check("t3 flushed", {31'h0, if_valid}, 32'h0);
        check("t3 count3", fetch_count, 32'd3);
        check("t3 pc8", im_address, 32'h8);
        step();
        check("t3 inst", if_inst, 32'hF0B7_AB1E);
        check("t3 if_pc", if_pc, 32'h8);

        // 4: wrap and bad redirect targets
        redirect_valid = 1'b1;
        redirect_pc = 32'd28;
        step();
        redirect_valid = 1'b0;
        check("t4 addr28", im_address, 32'd28);
        check("t4 no err", {31'h0, addr_err}, 32'h0);
        step();
        check("t4 if_pc28", if_pc, 32'd28);
        check("t4 wrap", im_address, 32'h0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0A;
        step();
        redirect_valid = 1'b0;
        check("t4 misalign err", {31'h0, addr_err}, 32'h1);
        check("t4 misalign pc", im_address, 32'h8);
        step();
        check("t4 err cleared", {31'h0, addr_err}, 32'h0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        step();
        redirect_valid = 1'b0;
        check("t4 range err", {31'h0, addr_err}, 32'h1);
        check("t4 range pc", im_address, 32'h0);

        // 5: HALT
        do_reset();
        mem[4] = HLT;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        check("t5 halt inst", if_inst, HLT);
        check("t5 halt pc", if_pc, 32'd16);
        #1 check("t5 im_en off", {31'h0, im_en}, 32'h0);
        step();
        #1 check("t5 still off", {31'h0, im_en}, 32'h0);
        start = 1'b1;
        step();
        start = 1'b0;
        #1 check("t5 resume addr", im_address, 32'd20);
        check("t5 resume en", {31'h0, im_en}, 32'h1);
        step();
        check("t5 resume if_pc", if_pc, 32'd20);

        // 6: asynchronous reset mid-stream
        step();
        check("t6 valid before", {31'h0, if_valid}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("t6 valid", {31'h0, if_valid}, 32'h0);
        check("t6 inst", if_inst, 32'h0);
        check("t6 count", fetch_count, 32'h0);
        check("t6 pc", im_address, 32'h0);
        check("t6 im_en", {31'h0, im_en}, 32'h0);
        step();
        rst_n = 1'b1;
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
